// File: rtl/change_dispenser.sv
// Greedy coin change dispenser: quarters, then dimes, then nickels, one coin per handshake.
// Define CHANGE_INVENTORY_EN to track tube contents; otherwise the tubes never run out.
module change_dispenser #(
    parameter int Q_INIT = 8,
    parameter int D_INIT = 8,
    parameter int N_INIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] amount,
    input  logic       refill,
    input  logic       coin_ready,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [6:0] residue,
    output logic [4:0] q_count,
    output logic [4:0] d_count,
    output logic [4:0] n_count
);

    typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} state_t;

    localparam logic [1:0] CT_NONE = 2'b00;
    localparam logic [1:0] CT_Q    = 2'b01;
    localparam logic [1:0] CT_D    = 2'b10;
    localparam logic [1:0] CT_N    = 2'b11;

    localparam logic [4:0] Q0 = 5'(Q_INIT);
    localparam logic [4:0] D0 = 5'(D_INIT);
    localparam logic [4:0] N0 = 5'(N_INIT);

`ifdef CHANGE_INVENTORY_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    state_t     state;
    logic [6:0] remaining;
    logic [6:0] coin_val;
    logic       handshake;
    logic       q_avail, d_avail, n_avail;

    assign handshake = (state == DISPENSE) && coin_valid && coin_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        coin_val = 7'd0;
        case (coin_type)
            CT_Q:    coin_val = 7'd25;
            CT_D:    coin_val = 7'd10;
            CT_N:    coin_val = 7'd5;
            default: coin_val = 7'd0;
        endcase
    end

`ifdef CHANGE_INVENTORY_EN
    logic [4:0] q_cnt, d_cnt, n_cnt;

    // refill has priority over a same-cycle decrement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_cnt <= Q0;
            d_cnt <= D0;
            n_cnt <= N0;
        end else if (refill) begin
            q_cnt <= Q0;
            d_cnt <= D0;
            n_cnt <= N0;
        end else if (handshake) begin
            case (coin_type)
                CT_Q:    if (q_cnt != 5'd0) q_cnt <= q_cnt - 5'd1;
                CT_D:    if (d_cnt != 5'd0) d_cnt <= d_cnt - 5'd1;
                CT_N:    if (n_cnt != 5'd0) n_cnt <= n_cnt - 5'd1;
                default: ;
            endcase
        end
    end

    assign q_count = q_cnt;
    assign d_count = d_cnt;
    assign n_count = n_cnt;
    assign q_avail = (q_cnt != 5'd0);
    assign d_avail = (d_cnt != 5'd0);
    assign n_avail = (n_cnt != 5'd0);
`else
    logic unused_refill;
    assign unused_refill = refill;

    assign q_count = Q0;
    assign d_count = D0;
    assign n_count = N0;
    assign q_avail = 1'b1;
    assign d_avail = 1'b1;
    assign n_avail = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= 7'd0;
            coin_valid <= 1'b0;
            coin_type  <= CT_NONE;
            done       <= 1'b0;
            short      <= 1'b0;
            residue    <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= amount;
                        residue   <= 7'd0;
                        short     <= 1'b0;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (remaining >= 7'd25 && q_avail) begin
                        coin_type  <= CT_Q;
                        coin_valid <= 1'b1;
                        state      <= DISPENSE;
                    end else if (remaining >= 7'd10 && d_avail) begin
                        coin_type  <= CT_D;
                        coin_valid <= 1'b1;
                        state      <= DISPENSE;
                    end else if (remaining >= 7'd5 && n_avail) begin
                        coin_type  <= CT_N;
                        coin_valid <= 1'b1;
                        state      <= DISPENSE;
                    end else begin
                        done    <= 1'b1;
                        residue <= remaining;
                        short   <= INV_EN && (remaining >= 7'd5);
                        state   <= DONE;
                    end
                end
                DISPENSE: begin
                    // coin_type is held until the mechanism takes the coin
                    if (coin_ready) begin
                        remaining  <= remaining - coin_val;
                        coin_valid <= 1'b0;
                        coin_type  <= CT_NONE;
                        state      <= SELECT;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: vector table of payouts plus handshake, reset and refill corners.
// Expectations adapt to whether CHANGE_INVENTORY_EN is defined for the build.
module tb_change_dispenser;

    localparam int QI = 8, DI = 8, NI = 8;
    localparam logic [1:0] CQ = 2'b01, CD = 2'b10, CN = 2'b11, C0 = 2'b00;

`ifdef CHANGE_INVENTORY_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, refill, coin_ready, start2;
    logic [6:0] amount;
    logic       coin_valid, busy, done, short;
    logic [1:0] coin_type;
    logic [6:0] residue;
    logic [4:0] q_count, d_count, n_count;
    logic       coin_valid2, busy2, done2, short2;
    logic [1:0] coin_type2;
    logic [6:0] residue2;
    logic [4:0] q_count2, d_count2, n_count2;

    always #5 clk = ~clk;

    change_dispenser #(.Q_INIT(QI), .D_INIT(DI), .N_INIT(NI)) dut (
        .clk(clk), .reset(reset), .start(start), .amount(amount), .refill(refill),
        .coin_ready(coin_ready), .coin_valid(coin_valid), .coin_type(coin_type),
        .busy(busy), .done(done), .short(short), .residue(residue),
        .q_count(q_count), .d_count(d_count), .n_count(n_count));

    change_dispenser #(.Q_INIT(1), .D_INIT(8), .N_INIT(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .amount(amount), .refill(refill),
        .coin_ready(coin_ready), .coin_valid(coin_valid2), .coin_type(coin_type2),
        .busy(busy2), .done(done2), .short(short2), .residue(residue2),
        .q_count(q_count2), .d_count(d_count2), .n_count(n_count2));

    typedef struct {
        logic [6:0] amt;
        int         n;
        logic [1:0] c [5];
        logic [6:0] res;
    } vec_t;

    int ncmp = 0, nfail = 0;

    int         got_n;
    logic [1:0] got_c [8];
    logic       got_done, got_sh, type_ok;
    logic [6:0] got_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] a, input int n,
                                input logic [1:0] c0, c1, c2, c3, c4, input logic [6:0] r);
        vec_t v;
        v.amt = a; v.n = n; v.res = r;
        v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3; v.c[4] = c4;
        return v;
    endfunction

    task automatic pulse_start(input logic [6:0] a);
        @(negedge clk); amount = a; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Collect coins from the primary instance until done or the cycle budget expires.
    task automatic collect();
        got_n = 0; got_done = 1'b0; type_ok = 1'b1; got_res = 7'd0; got_sh = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!coin_valid && coin_type != C0) type_ok = 1'b0;
            if (coin_valid && coin_ready) begin
                if (got_n < 8) got_c[got_n] = coin_type;
                got_n++;
            end
            if (done) begin
                got_done = 1'b1; got_res = residue; got_sh = short;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_refill();
        @(negedge clk); refill = 1'b1;
        @(negedge clk); refill = 1'b0;
    endtask

    vec_t vecs [10];

    initial begin
        int nq, nd, nn;
        bit stable, no_done;

        vecs[0] = mk(7'd65,  4, CQ, CQ, CD, CN, C0, 7'd0);
        vecs[1] = mk(7'd42,  3, CQ, CD, CN, C0, C0, 7'd2);
        vecs[2] = mk(7'd0,   0, C0, C0, C0, C0, C0, 7'd0);
        vecs[3] = mk(7'd4,   0, C0, C0, C0, C0, C0, 7'd4);
        vecs[4] = mk(7'd127, 5, CQ, CQ, CQ, CQ, CQ, 7'd2);
        vecs[5] = mk(7'd99,  5, CQ, CQ, CQ, CD, CD, 7'd4);
        vecs[6] = mk(7'd30,  2, CQ, CN, C0, C0, C0, 7'd0);
        vecs[7] = mk(7'd15,  2, CD, CN, C0, C0, C0, 7'd0);
        vecs[8] = mk(7'd5,   1, CN, C0, C0, C0, C0, 7'd0);
        vecs[9] = mk(7'd24,  2, CD, CD, C0, C0, C0, 7'd4);

        reset = 1'b1; start = 1'b0; start2 = 1'b0; refill = 1'b0;
        coin_ready = 1'b1; amount = 7'd0;
        repeat (3) @(negedge clk);
        chk("reset coin_valid", coin_valid, 0);
        chk("reset coin_type", coin_type, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset short", short, 0);
        chk("reset residue", residue, 0);
        chk("reset q_count", q_count, QI);
        chk("reset d_count", d_count, DI);
        chk("reset n_count", n_count, NI);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            pulse_refill();
            pulse_start(vecs[i].amt);
            collect();
            chk($sformatf("v%0d done", i), got_done, 1);
            chk($sformatf("v%0d ncoins", i), got_n, vecs[i].n);
            nq = 0; nd = 0; nn = 0;
            for (int k = 0; k < vecs[i].n && k < got_n; k++) begin
                chk($sformatf("v%0d coin%0d", i, k), got_c[k], vecs[i].c[k]);
            end
            for (int k = 0; k < vecs[i].n; k++) begin
                if (vecs[i].c[k] == CQ) nq++;
                if (vecs[i].c[k] == CD) nd++;
                if (vecs[i].c[k] == CN) nn++;
            end
            chk($sformatf("v%0d residue", i), got_res, vecs[i].res);
            chk($sformatf("v%0d short", i), got_sh, 0);
            chk($sformatf("v%0d type_idle", i), type_ok, 1);
            chk($sformatf("v%0d q_count", i), q_count, INV ? QI - nq : QI);
            chk($sformatf("v%0d d_count", i), d_count, INV ? DI - nd : DI);
            chk($sformatf("v%0d n_count", i), n_count, INV ? NI - nn : NI);
            @(negedge clk);
            chk($sformatf("v%0d done_1cyc", i), done, 0);
            chk($sformatf("v%0d idle", i), busy, 0);
            chk($sformatf("v%0d residue_held", i), residue, vecs[i].res);
        end

        // first coin appears two cycles after start; held while coin_ready is low
        pulse_refill();
        coin_ready = 1'b0;
        pulse_start(7'd50);
        chk("lat coin_valid@1", coin_valid, 0);
        chk("lat busy@1", busy, 1);
        @(negedge clk);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!(coin_valid === 1'b1 && coin_type === CQ)) stable = 1'b0;
            @(negedge clk);
        end
        chk("stall stable", stable, 1);
        coin_ready = 1'b1;
        collect();
        chk("stall done", got_done, 1);
        chk("stall ncoins", got_n, 2);
        chk("stall coin0", got_c[0], CQ);
        chk("stall coin1", got_c[1], CQ);
        chk("stall residue", got_res, 0);

        // reset while the second coin of 65 is on offer
        pulse_refill();
        pulse_start(7'd65);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst pre coin_valid", coin_valid, 1);
        reset = 1'b1;
        #1;
        chk("rst coin_valid", coin_valid, 0);
        chk("rst coin_type", coin_type, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst residue", residue, 0);
        chk("rst q_count", q_count, QI);
        @(negedge clk);
        reset = 1'b0;
        no_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        chk("rst no_done", no_done, 1);

        // refill on a quarter handshake, plus a start while busy
        pulse_refill();
        @(negedge clk); amount = 7'd25; start = 1'b1;
        @(negedge clk); amount = 7'd100; start = 1'b1;
        chk("busy_start busy", busy, 1);
        @(negedge clk); start = 1'b0;
        chk("refill coin", coin_type, CQ);
        refill = 1'b1;
        @(negedge clk); refill = 1'b0;
        chk("refill wins q_count", q_count, QI);
        collect();
        chk("busy_start done", got_done, 1);
        chk("busy_start ncoins", got_n, 0);
        chk("busy_start residue", got_res, 0);
        repeat (3) @(negedge clk);
        chk("busy_start stays idle", busy, 0);
        chk("refill q_count after", q_count, QI);

        // no backtracking: 30 cents with one quarter and no nickels
        @(negedge clk); amount = 7'd30; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        got_n = 0; got_done = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (coin_valid2 && coin_ready) begin
                if (got_n < 8) got_c[got_n] = coin_type2;
                got_n++;
            end
            if (done2) begin
                got_done = 1'b1; got_res = residue2; got_sh = short2;
                break;
            end
            @(negedge clk);
        end
        chk("nb done", got_done, 1);
        chk("nb coin0", got_c[0], CQ);
        chk("nb ncoins", got_n, INV ? 1 : 2);
        chk("nb short", got_sh, INV ? 1 : 0);
        chk("nb residue", got_res, INV ? 5 : 0);
        chk("nb q_count", q_count2, INV ? 0 : 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL provide parameter Q_INIT, default 8: quarter tube count loaded at reset/refill.
REQ-002 SHALL provide parameter D_INIT, default 8: dime tube count loaded at reset/refill.
REQ-003 SHALL provide parameter N_INIT, default 8: nickel tube count loaded at reset/refill.
REQ-004 SHALL have clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have start  input  1  one-cycle request to pay out amount.
REQ-007 SHALL have amount  input  7  change owed in cents, unsigned, 0..127.
REQ-008 SHALL have refill  input  1  one-cycle pulse reloading all tubes to *_INIT.
REQ-009 SHALL have coin_ready  input  1  coin mechanism accepts current coin.
REQ-010 SHALL have coin_valid  output  1  a coin is offered for ejection.
REQ-011 SHALL have coin_type  output  2  01 quarter, 10 dime, 11 nickel, 00 none.
REQ-012 SHALL have busy  output  1  high in every state except IDLE.
REQ-013 SHALL have done  output  1  one-cycle completion pulse.
REQ-014 SHALL have short  output  1  valid with done; payout incomplete for lack of coins.
REQ-015 SHALL have residue  output  7  cents not paid, held from done until next start.
REQ-016 SHALL have q_count, d_count, n_count  output  5 each  current tube contents.

Function
REQ-017 SHALL implement FSM states IDLE, SELECT, DISPENSE, DONE.
REQ-018 IDLE: start=1 SHALL latch amount into 7-bit remaining and go to SELECT next cycle; start ignored in all other states.
REQ-019 SELECT (one cycle) SHALL pick greedily: remaining>=25 and q_count>0 -> quarter; else remaining>=10 and d_count>0 -> dime; else remaining>=5 and n_count>0 -> nickel; else go to DONE.
REQ-020 On a pick, SHALL register coin_type and enter DISPENSE; first coin_valid is therefore 2 cycles after start.
REQ-021 DISPENSE: coin_valid=1, coin_type SHALL be stable until the cycle coin_valid&&coin_ready.
REQ-022 On handshake, SHALL subtract 25/10/5 from remaining, decrement the matching tube count, return to SELECT; coin_valid SHALL be 0 in SELECT (max one coin per 2 cycles).
REQ-023 DONE (one cycle): done=1, residue=remaining, short=(remaining>=5); then IDLE.
REQ-024 amount=0 or <5 SHALL go start->SELECT->DONE with no coin, short=0, residue=amount.
REQ-025 Greedy order SHALL NOT backtrack (e.g. 30 with no nickels, quarters present -> quarter then short=1, residue=5).
REQ-026 Tube counts SHALL saturate at 0 and never underflow.
REQ-027 refill SHALL load *_INIT next edge in any state; refill coinciding with a handshake decrement SHALL win (count = *_INIT).
REQ-028 coin_type SHALL be 00 whenever coin_valid=0.

Reset
REQ-029 Reset SHALL force IDLE, remaining=0, coin_valid=0, coin_type=00, done=0, short=0, residue=0, busy=0, counts=*_INIT.
REQ-030 Reset mid-DISPENSE SHALL abort the payout immediately; no done pulse SHALL follow.

Configuration
REQ-031 With CHANGE_INVENTORY_EN defined, tube counts SHALL be tracked and gate selection per REQ-019/026/027.
REQ-032 Without CHANGE_INVENTORY_EN, tubes SHALL be treated as unlimited, counts outputs SHALL read constant *_INIT, refill SHALL be ignored, short SHALL always be 0.

Verification
REQ-033 amount=65, coin_ready=1 -> Q,Q,D,N; done, residue=0, short=0; q_count=6, d_count=7, n_count=7.
REQ-034 amount=42 -> Q,D,N; done with residue=2, short=0.
REQ-035 amount=50, coin_ready low 10 cycles on first coin -> coin_valid/coin_type=01 held stable all 10 cycles, then Q,Q.
REQ-036 Q_INIT=1, N_INIT=0, amount=30 (macro on) -> one Q; done, short=1, residue=5, q_count=0.
REQ-037 reset asserted during second coin of amount=65 -> all outputs at reset values, counts=*_INIT, no done.
REQ-038 refill asserted on same cycle as a quarter handshake -> q_count=Q_INIT next cycle; start during busy ignored.
